// File: rtl/rf_level_ctrl_pkg.sv
// Shared definitions for the banked register-file level controller.
//   NumLevels   : default number of priority levels / register banks
//   LevelsWidth : width of a level number
//   LevelT      : level number type
//   DataWidth   : default width of the jump-target bus
//   Marker      : return-marker address (all ones)
//   state_e     : controller FSM states
package rf_stack_pkg;

  localparam int NumLevels   = 8;
  localparam int LevelsWidth = $clog2(NumLevels);
  localparam int DataWidth   = 32;

  typedef logic [LevelsWidth-1:0] LevelT;

  localparam logic [DataWidth-1:0] Marker = '1;

  typedef enum logic {
    RUN   = 1'b0,
    ENTER = 1'b1
  } state_e;

endpackage

// File: rtl/rf_level_ctrl_if.sv
// Bundle of signals between the interrupt arbiter, the core and the
// register-file level controller.
//   irqValid/irqLevel/irqAck : interrupt request handshake (arbiter side)
//   jumpValid/jumpTarget     : committed jump from the core
//   level/writeRaEn          : register-file bank select and marker strobe
//   stall/depth/retErr       : core hold, stacked-level count, sticky error
// Modports: master = the controller, slave = its environment.
interface rf_level_ctrl_if #(
  parameter int NumLevels = 8,
  parameter int DataWidth = 32
);
  localparam int LevelW = $clog2(NumLevels);

  logic                 irqValid;
  logic [LevelW-1:0]    irqLevel;
  logic                 irqAck;
  logic                 jumpValid;
  logic [DataWidth-1:0] jumpTarget;
  logic [LevelW-1:0]    level;
  logic                 writeRaEn;
  logic                 stall;
  logic [LevelW:0]      depth;
  logic                 retErr;

  modport master (
    input  irqValid, irqLevel, jumpValid, jumpTarget,
    output irqAck, level, writeRaEn, stall, depth, retErr
  );

  modport slave (
    output irqValid, irqLevel, jumpValid, jumpTarget,
    input  irqAck, level, writeRaEn, stall, depth, retErr
  );

endinterface

// File: rtl/rf_level_ctrl_lifo.sv
// level_lifo: stack of preempted priority levels.
//   clk, reset : clock, synchronous active-high reset (clears count only)
//   push, din  : push din onto the stack (ignored when full)
//   pop        : discard the top entry (ignored when empty)
//   top        : current top entry (zero when empty)
//   count      : number of stored entries
//   full/empty : stack status
// Push and pop in the same cycle is illegal.
module level_lifo #(
  parameter int Depth  = 7,
  parameter int Width  = 3,
  localparam int CountW = $clog2(Depth + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [Width-1:0]  din,
  output logic [Width-1:0]  top,
  output logic [CountW-1:0] count,
  output logic              full,
  output logic              empty
);

  logic [Width-1:0]  mem [Depth];
  logic [CountW-1:0] cnt;

  assign full  = (cnt == CountW'(Depth));
  assign empty = (cnt == '0);
  assign count = cnt;
  assign top   = empty ? '0 : mem[cnt - CountW'(1)];

  // NOTE: sequential state is updated with non-blocking assignments so
  // every register samples the pre-edge values regardless of block order.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (push && !full) begin
      cnt <= cnt + CountW'(1);
    end else if (pop && !empty) begin
      cnt <= cnt - CountW'(1);
    end
  end

  // NOTE: the storage array is deliberately not reset; entries above count
  // are never read, so clearing them would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[cnt] <= din;
    end
  end

  a_no_push_pop: assert property (@(posedge clk) disable iff (reset)
    !(push && pop));

endmodule

// File: rtl/rf_level_ctrl.sv
// rf_level_ctrl: drives the level/writeRaEn inputs of the banked register
// file, tracks the active interrupt priority level and stacks preempted
// levels. An accepted interrupt switches banks and spends one ENTER cycle
// (stall) while the register file writes the return marker into ra; a jump
// to the marker address restores the preempted level.
//   clk   : clock
//   reset : synchronous, active-high reset
//   bus   : rf_level_ctrl_if.master (irq handshake, jump, level outputs)
// Optional feature: define RF_LEVEL_TAIL_CHAIN_EN to let a pending higher
// interrupt replace a return directly (tail chaining) instead of popping.
module rf_level_ctrl
  import rf_stack_pkg::*;
#(
  parameter int NumLevels = 8,
  parameter int DataWidth = 32
) (
  input  logic clk,
  input  logic reset,
  rf_level_ctrl_if.master bus
);

  localparam int LevelW = $clog2(NumLevels);

  state_e            state_q, state_d;
  logic [LevelW-1:0] level_q, level_d;
  logic              ret_err_q, ret_err_d;

  logic              push, pop;
  logic [LevelW-1:0] stack_top;
  logic [LevelW-1:0] stack_count;
  logic              stack_full, stack_empty;

  logic              is_return;
  logic              irq_ack;
  logic              write_ra_en;
  logic              stall;

  level_lifo #(
    .Depth (NumLevels - 1),
    .Width (LevelW)
  ) u_lifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (level_q),
    .top   (stack_top),
    .count (stack_count),
    .full  (stack_full),
    .empty (stack_empty)
  );

  assign is_return = bus.jumpValid && (bus.jumpTarget == {DataWidth{1'b1}});

  // NOTE: every signal written here gets a default first, so no path through
  // the case/if tree can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    ret_err_d   = ret_err_q;
    push        = 1'b0;
    pop         = 1'b0;
    irq_ack     = 1'b0;
    write_ra_en = 1'b0;
    stall       = 1'b0;

    unique case (state_q)
      RUN: begin
        if (is_return) begin
          if (!stack_empty) begin
`ifdef RF_LEVEL_TAIL_CHAIN_EN
            // Tail chain: the interrupt takes over the returning frame, so
            // the stacked level stays where it is.
            if (bus.irqValid && (bus.irqLevel > stack_top)) begin
              level_d = bus.irqLevel;
              irq_ack = 1'b1;
              state_d = ENTER;
            end else begin
              pop     = 1'b1;
              level_d = stack_top;
            end
`else
            pop     = 1'b1;
            level_d = stack_top;
`endif
          end else begin
            ret_err_d = 1'b1;
          end
        end else if (bus.irqValid && (bus.irqLevel > level_q) && !stack_full) begin
          // Return has priority above; a pending irq is re-evaluated next
          // cycle against the restored level.
          push    = 1'b1;
          level_d = bus.irqLevel;
          irq_ack = 1'b1;
          state_d = ENTER;
        end
      end
      ENTER: begin
        // level already holds the new bank; the register file writes the
        // marker into ra of that bank during this cycle.
        write_ra_en = 1'b1;
        stall       = 1'b1;
        state_d     = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RUN;
      level_q   <= '0;
      ret_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      ret_err_q <= ret_err_d;
    end
  end

  assign bus.irqAck    = irq_ack && !reset;
  assign bus.writeRaEn = write_ra_en;
  assign bus.stall     = stall;
  assign bus.level     = level_q;
  assign bus.depth     = (LevelW + 1)'(stack_count);
  assign bus.retErr    = ret_err_q;

  a_no_jump_in_enter: assert property (@(posedge clk) disable iff (reset)
    (state_q == ENTER) |-> !bus.jumpValid);

endmodule

// File: tb/tb_rf_level_ctrl.sv
// Self-checking bench for rf_level_ctrl. Each driven cycle pushes the
// outputs expected in that cycle onto a scoreboard; a monitor pops and
// compares them shortly before the next rising edge.
module tb_rf_level_ctrl;

  localparam int NL = 8;
  localparam int DW = 32;
  localparam logic [DW-1:0] M = 32'hFFFF_FFFF;

  typedef struct {
    string      tag;
    logic       ack;
    logic [2:0] lvl;
    logic [3:0] dep;
    logic       wr;
    logic       st;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  rf_level_ctrl_if #(.NumLevels(NL), .DataWidth(DW)) bus ();

  rf_level_ctrl #(.NumLevels(NL), .DataWidth(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus and, if chk, queue the outputs expected
  // during that same cycle.
  task automatic cyc(input string tag, input bit rst, input bit irqv, input int irql,
                     input bit jv, input logic [DW-1:0] jt, input bit chk,
                     input bit e_ack, input int e_lvl, input int e_dep,
                     input bit e_wr, input bit e_st, input bit e_err);
    exp_t e;
    @(negedge clk);
    reset          = rst;
    bus.irqValid   = irqv;
    bus.irqLevel   = 3'(irql);
    bus.jumpValid  = jv;
    bus.jumpTarget = jt;
    if (chk) begin
      e.tag = tag; e.ack = e_ack; e.lvl = 3'(e_lvl); e.dep = 4'(e_dep);
      e.wr = e_wr; e.st = e_st; e.err = e_err;
      sb.push_back(e);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.tag, ".ack"},   32'(bus.irqAck),    32'(e.ack));
        check({e.tag, ".level"}, 32'(bus.level),     32'(e.lvl));
        check({e.tag, ".depth"}, 32'(bus.depth),     32'(e.dep));
        check({e.tag, ".wr"},    32'(bus.writeRaEn), 32'(e.wr));
        check({e.tag, ".stall"}, 32'(bus.stall),     32'(e.st));
        check({e.tag, ".err"},   32'(bus.retErr),    32'(e.err));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    reset = 1'b1;
    bus.irqValid = 1'b0; bus.irqLevel = '0; bus.jumpValid = 1'b0; bus.jumpTarget = '0;

    // Reset and idle.
    cyc("rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc("idle", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);

    // First entry to level 3.
    cyc("acc3", 0, 1, 3, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    cyc("ent3", 0, 0, 0, 0, 0, 1, 0, 3, 1, 1, 1, 0);
    cyc("run3", 0, 0, 0, 0, 0, 1, 0, 3, 1, 0, 0, 0);

    // Nest to level 5, then unwind twice.
    cyc("acc5", 0, 1, 5, 0, 0, 1, 1, 3, 1, 0, 0, 0);
    cyc("ent5", 0, 0, 0, 0, 0, 1, 0, 5, 2, 1, 1, 0);
    cyc("run5", 0, 0, 0, 0, 0, 1, 0, 5, 2, 0, 0, 0);
    cyc("ret5", 0, 0, 0, 1, M, 1, 0, 5, 2, 0, 0, 0);
    cyc("ret3", 0, 0, 0, 1, M, 1, 0, 3, 1, 0, 0, 0);
    cyc("lvl0", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);

    // Lower-priority request stays pending until the level drops.
    cyc("acc3b", 0, 1, 3, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    cyc("ent3b", 0, 0, 0, 0, 0, 1, 0, 3, 1, 1, 1, 0);
    for (int i = 0; i < 10; i++) cyc("low", 0, 1, 2, 0, 0, 1, 0, 3, 1, 0, 0, 0);
    cyc("nomark", 0, 1, 2, 1, 32'hFFFF_FFFE, 1, 0, 3, 1, 0, 0, 0);
    cyc("retlo", 0, 1, 2, 1, M, 1, 0, 3, 1, 0, 0, 0);
    cyc("acclo", 0, 1, 2, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    cyc("entlo", 0, 0, 0, 0, 0, 1, 0, 2, 1, 1, 1, 0);
    cyc("run2", 0, 0, 0, 0, 0, 1, 0, 2, 1, 0, 0, 0);

    // Return together with a higher request at level 2, depth 1.
`ifdef RF_LEVEL_TAIL_CHAIN_EN
    cyc("tail", 0, 1, 4, 1, M, 1, 1, 2, 1, 0, 0, 0);
    cyc("tailent", 0, 0, 0, 0, 0, 1, 0, 4, 1, 1, 1, 0);
`else
    cyc("rwin", 0, 1, 4, 1, M, 1, 0, 2, 1, 0, 0, 0);
    cyc("acc4", 0, 1, 4, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    cyc("ent4", 0, 0, 0, 0, 0, 1, 0, 4, 1, 1, 1, 0);
`endif
    cyc("run4", 0, 0, 0, 0, 0, 1, 0, 4, 1, 0, 0, 0);
    cyc("ret4", 0, 0, 0, 1, M, 1, 0, 4, 1, 0, 0, 0);
    cyc("lvl0b", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);

    // Fill the stack with levels 1..7, then unwind it completely.
    for (int i = 1; i < NL; i++) begin
      cyc("chain", 0, 1, i, 0, 0, 1, 1, i - 1, i - 1, 0, 0, 0);
      cyc("chent", 0, 0, 0, 0, 0, 1, 0, i, i, 1, 1, 0);
    end
    for (int i = 0; i < 3; i++) cyc("full", 0, 1, 7, 0, 0, 1, 0, 7, 7, 0, 0, 0);
    for (int k = NL - 1; k >= 1; k--) cyc("unwind", 0, 0, 0, 1, M, 1, 0, k, k, 0, 0, 0);
    cyc("empty", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);

    // Return with an empty stack sets a sticky error; reset clears it.
    cyc("reterr", 0, 0, 0, 1, M, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc("sticky", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    cyc("rst2", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("errclr", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);

    // Reset during ENTER aborts the entry.
    cyc("acc6", 0, 1, 6, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    cyc("rstent", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("abort", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    cyc("abort2", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #4;
    check("drain", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
